fpga_temp_monitor: RTL and testbench

//   Consumes the lclk-domain 12-bit FPGA temperature code produced by the DDR3->lclk temperature CDC stage.

---
 rtl/fpga_temp_monitor_pkg.sv | 17 +
 rtl/temp_avg_accum.sv | 38 +++
 rtl/fpga_temp_monitor.sv | 129 ++++++++++++
 tb/tb_fpga_temp_monitor.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_temp_monitor_pkg.sv
// Shared definitions for the FPGA temperature monitor: default code width,
// FSM state encoding and a saturating event-counter helper.
package fpga_temp_monitor_pkg;

    localparam int TEMP_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SAMPLE = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/temp_avg_accum.sv
// Box-car accumulator: sums 2^AVG_LOG2 accepted samples and presents the
// truncated average; done flags that the next accepted sample completes the set.
module temp_avg_accum #(
    parameter int TEMP_W   = 12,
    parameter int AVG_LOG2 = 4
) (
    input  logic              lclk,
    input  logic              lclk_rst,
    input  logic              add,
    input  logic              clear,
    input  logic [TEMP_W-1:0] sample,
    output logic              done,
    output logic [TEMP_W-1:0] avg
);

    localparam int ACC_W = TEMP_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] n_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge lclk) begin
        if (lclk_rst || clear) begin
            acc   <= '0;
            n_cnt <= '0;
        end else if (add) begin
            acc   <= acc + ACC_W'(sample);
            n_cnt <= n_cnt + CNT_W'(1);
        end
    end

    assign done = (n_cnt == CNT_LAST);
    assign avg  = TEMP_W'(acc >> AVG_LOG2);

endmodule

// File: rtl/fpga_temp_monitor.sv
// Periodic temperature sampler with averaging, over-temperature alarm and
// optional raw min/max tracking (enabled by defining TEMP_MON_MINMAX_EN).
module fpga_temp_monitor
    import fpga_temp_monitor_pkg::*;
#(
    parameter int          TEMP_W     = TEMP_W_DEFAULT,
    parameter logic [15:0] SAMPLE_DIV = 16'd1000,
    parameter int          AVG_LOG2   = 4
) (
    input  logic              lclk,
    input  logic              lclk_rst,
    input  logic [TEMP_W-1:0] device_temp,
    input  logic [TEMP_W-1:0] hi_thresh,
    input  logic [TEMP_W-1:0] lo_thresh,
    input  logic              minmax_clr,
    output logic [TEMP_W-1:0] avg_temp,
    output logic              avg_valid,
    output logic [TEMP_W-1:0] temp_min,
    output logic [TEMP_W-1:0] temp_max,
    output logic              over_temp,
    output logic [15:0]       over_temp_cnt
);

    localparam logic [TEMP_W-1:0] TEMP_MIN_INIT = '1;

    state_t            state, state_next;
    logic [15:0]       div_cnt;
    logic              div_last;
    logic              accept;
    logic              do_update;
    logic              acc_done;
    logic [TEMP_W-1:0] acc_avg;

    assign div_last = (div_cnt == SAMPLE_DIV - 16'd1);

    always_ff @(posedge lclk) begin
        if (lclk_rst) state <= S_WAIT;
        else          state <= state_next;
    end

    always_ff @(posedge lclk) begin
        if (lclk_rst)              div_cnt <= '0;
        else if (state == S_WAIT)  div_cnt <= div_last ? '0 : div_cnt + 16'd1;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_update  = 1'b0;
        case (state)
            S_WAIT: begin
                if (div_last) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                state_next = S_WAIT;
                // A zero code means the CDC stage has no reading yet.
                if (device_temp != '0) begin
                    accept = 1'b1;
                    if (acc_done) state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                do_update  = 1'b1;
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase
    end

    temp_avg_accum #(
        .TEMP_W   (TEMP_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .lclk     (lclk),
        .lclk_rst (lclk_rst),
        .add      (accept),
        .clear    (do_update),
        .sample   (device_temp),
        .done     (acc_done),
        .avg      (acc_avg)
    );

    always_ff @(posedge lclk) begin
        if (lclk_rst) begin
            avg_temp      <= '0;
            avg_valid     <= 1'b0;
            over_temp     <= 1'b0;
            over_temp_cnt <= '0;
        end else begin
            avg_valid <= do_update;
            if (do_update) begin
                avg_temp <= acc_avg;
                // Set is tested first so it wins when the thresholds overlap.
                if (acc_avg >= hi_thresh) begin
                    over_temp <= 1'b1;
                    if (!over_temp) over_temp_cnt <= sat_inc16(over_temp_cnt);
                end else if (acc_avg < lo_thresh) begin
                    over_temp <= 1'b0;
                end
            end
        end
    end

`ifdef TEMP_MON_MINMAX_EN
    always_ff @(posedge lclk) begin
        if (lclk_rst) begin
            temp_min <= TEMP_MIN_INIT;
            temp_max <= '0;
        end else if (minmax_clr && accept) begin
            temp_min <= device_temp;
            temp_max <= device_temp;
        end else if (minmax_clr) begin
            temp_min <= TEMP_MIN_INIT;
            temp_max <= '0;
        end else if (accept) begin
            if (device_temp < temp_min) temp_min <= device_temp;
            if (device_temp > temp_max) temp_max <= device_temp;
        end
    end
`else
    logic unused_minmax_clr;
    assign unused_minmax_clr = minmax_clr;
    assign temp_min          = TEMP_MIN_INIT;
    assign temp_max          = '0;
`endif

endmodule

// File: tb/tb_fpga_temp_monitor.sv
// Scoreboard bench for fpga_temp_monitor (SAMPLE_DIV=4, AVG_LOG2=2) plus a
// fast instance (SAMPLE_DIV=1, AVG_LOG2=0) for alarm-counter saturation.
module tb_fpga_temp_monitor;

    localparam logic [15:0] SD       = 16'd4;
    localparam int          AL       = 2;
    localparam int          N        = 1 << AL;
    localparam logic [11:0] MIN_INIT = 12'hFFF;

    typedef struct {
        int          cyc;
        logic [11:0] avg;
    } exp_t;

    logic        lclk;
    logic        lclk_rst;
    logic [11:0] device_temp, hi_thresh, lo_thresh;
    logic        minmax_clr;
    logic [11:0] avg_temp, temp_min, temp_max;
    logic        avg_valid, over_temp;
    logic [15:0] over_temp_cnt;

    logic        rst2;
    logic [11:0] temp2, hi2, lo2;
    logic [11:0] avg2, min2, max2;
    logic        valid2, ot2;
    logic [15:0] cnt2;

    exp_t        sb[$];
    int          n_cmp, n_err, cyc;
    int          m_n, m_sum;
    logic        m_ot;
    logic [15:0] m_cnt;
    logic [11:0] m_min, m_max;

    fpga_temp_monitor #(.TEMP_W(12), .SAMPLE_DIV(SD), .AVG_LOG2(AL)) dut (
        .lclk(lclk), .lclk_rst(lclk_rst), .device_temp(device_temp),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .minmax_clr(minmax_clr),
        .avg_temp(avg_temp), .avg_valid(avg_valid), .temp_min(temp_min),
        .temp_max(temp_max), .over_temp(over_temp), .over_temp_cnt(over_temp_cnt)
    );

    fpga_temp_monitor #(.TEMP_W(12), .SAMPLE_DIV(16'd1), .AVG_LOG2(0)) dut2 (
        .lclk(lclk), .lclk_rst(rst2), .device_temp(temp2),
        .hi_thresh(hi2), .lo_thresh(lo2), .minmax_clr(1'b0),
        .avg_temp(avg2), .avg_valid(valid2), .temp_min(min2),
        .temp_max(max2), .over_temp(ot2), .over_temp_cnt(cnt2)
    );

    initial lclk = 1'b0;
    always #5 lclk = ~lclk;

    always @(posedge lclk) cyc <= cyc + 1;

    // Every avg_valid pulse must match the oldest expected average and cycle.
    always @(negedge lclk) begin
        if (!lclk_rst && avg_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL avg_unexpected: pulse at cycle %0d avg=%h, none expected", cyc, avg_temp);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (avg_temp !== e.avg || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL avg_result: got avg=%h at cycle %0d, expected avg=%h at cycle %0d",
                             avg_temp, cyc, e.avg, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    task automatic do_reset();
        lclk_rst    = 1'b1;
        minmax_clr  = 1'b0;
        device_temp = '0;
        repeat (3) tick();
    endtask

    task automatic release_reset();
        lclk_rst = 1'b0;
        cyc      = 0;
        m_n      = 0;
        m_sum    = 0;
        m_ot     = 1'b0;
        m_cnt    = '0;
        m_min    = MIN_INIT;
        m_max    = '0;
        sb.delete();
    endtask

    // One sample slot: SD wait cycles then the sample edge; the model pushes
    // the expected average whenever the N-th accepted sample lands.
    task automatic run_slot(input logic [11:0] v, input logic clr);
        logic [11:0] a;
        exp_t        e;
        device_temp = v;
        repeat (SD) tick();
        minmax_clr = clr;
        tick();
        minmax_clr = 1'b0;
`ifdef TEMP_MON_MINMAX_EN
        if (clr) begin
            m_min = MIN_INIT;
            m_max = '0;
        end
        if (v != 0) begin
            if (clr) begin
                m_min = v;
                m_max = v;
            end else begin
                if (v < m_min) m_min = v;
                if (v > m_max) m_max = v;
            end
        end
`endif
        if (v != 0) begin
            m_sum += int'(v);
            m_n++;
        end
        if (m_n == N) begin
            a     = 12'(m_sum >> AL);
            e.cyc = cyc + 1;
            e.avg = a;
            sb.push_back(e);
            tick();
            if (a >= hi_thresh) begin
                if (!m_ot && m_cnt != 16'hFFFF) m_cnt++;
                m_ot = 1'b1;
            end else if (a < lo_thresh) begin
                m_ot = 1'b0;
            end
            m_n   = 0;
            m_sum = 0;
            @(negedge lclk);
            #1;
            n_cmp++;
            if (sb.size() != 0) begin
                n_err++;
                $display("FAIL avg_missing: %0d expected averages not seen by cycle %0d", sb.size(), cyc);
                sb.delete();
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 6;
        if (avg_temp !== 12'h000)      begin n_err++; $display("FAIL reset_avg: got %h want 000", avg_temp); end
        if (avg_valid !== 1'b0)        begin n_err++; $display("FAIL reset_valid: got %b want 0", avg_valid); end
        if (temp_min !== 12'hFFF)      begin n_err++; $display("FAIL reset_min: got %h want fff", temp_min); end
        if (temp_max !== 12'h000)      begin n_err++; $display("FAIL reset_max: got %h want 000", temp_max); end
        if (over_temp !== 1'b0)        begin n_err++; $display("FAIL reset_ot: got %b want 0", over_temp); end
        if (over_temp_cnt !== 16'h0)   begin n_err++; $display("FAIL reset_cnt: got %h want 0000", over_temp_cnt); end
    endtask

    task automatic test_steady();
        hi_thresh = 12'hFFF;
        lo_thresh = 12'h000;
        release_reset();
        n_cmp++;
        if (cyc != 0) begin n_err++; $display("FAIL steady_start: cycle %0d want 0", cyc); end
        for (int i = 0; i < N; i++) run_slot(12'h800, 1'b0);
        n_cmp += 2;
        if (temp_min !== m_min) begin n_err++; $display("FAIL steady_min: got %h want %h", temp_min, m_min); end
        if (temp_max !== m_max) begin n_err++; $display("FAIL steady_max: got %h want %h", temp_max, m_max); end
    endtask

    task automatic test_truncation();
        logic [11:0] vals [4];
        vals = '{12'd100, 12'd101, 12'd102, 12'd104};
        for (int i = 0; i < 4; i++) run_slot(vals[i], 1'b0);
        n_cmp += 2;
        if (temp_min !== m_min) begin n_err++; $display("FAIL trunc_min: got %h want %h", temp_min, m_min); end
        if (temp_max !== m_max) begin n_err++; $display("FAIL trunc_max: got %h want %h", temp_max, m_max); end
    endtask

    task automatic test_zero_drop();
        do_reset();
        release_reset();
        run_slot(12'h000, 1'b0);
        run_slot(12'h000, 1'b0);
        for (int i = 0; i < N; i++) run_slot(12'h500, 1'b0);
        n_cmp += 2;
        if (temp_min !== m_min) begin n_err++; $display("FAIL zero_min: got %h want %h", temp_min, m_min); end
        if (temp_max !== m_max) begin n_err++; $display("FAIL zero_max: got %h want %h", temp_max, m_max); end
    endtask

    task automatic test_alarm();
        logic [11:0] temps [7];
        logic [11:0] his   [7];
        logic [11:0] los   [7];
        temps = '{12'hA00, 12'h950, 12'h900, 12'h8FF, 12'hA10, 12'h8FF, 12'h350};
        his   = '{12'hA00, 12'hA00, 12'hA00, 12'hA00, 12'hA00, 12'hA00, 12'h300};
        los   = '{12'h900, 12'h900, 12'h900, 12'h900, 12'h900, 12'h900, 12'h400};
        do_reset();
        release_reset();
        for (int b = 0; b < 7; b++) begin
            hi_thresh = his[b];
            lo_thresh = los[b];
            for (int i = 0; i < N; i++) run_slot(temps[b], 1'b0);
            n_cmp += 2;
            if (over_temp !== m_ot) begin
                n_err++;
                $display("FAIL alarm_level[%0d]: got %b want %b", b, over_temp, m_ot);
            end
            if (over_temp_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL alarm_count[%0d]: got %h want %h", b, over_temp_cnt, m_cnt);
            end
        end
        hi_thresh = 12'hFFF;
        lo_thresh = 12'h000;
    endtask

    task automatic test_minmax_clr();
        do_reset();
        release_reset();
        run_slot(12'h300, 1'b0);
        run_slot(12'h900, 1'b0);
        run_slot(12'h650, 1'b0);
        run_slot(12'h700, 1'b1);
        n_cmp += 2;
        if (temp_min !== m_min) begin n_err++; $display("FAIL clr_sample_min: got %h want %h", temp_min, m_min); end
        if (temp_max !== m_max) begin n_err++; $display("FAIL clr_sample_max: got %h want %h", temp_max, m_max); end
        minmax_clr = 1'b1;
        tick();
        minmax_clr = 1'b0;
        m_min = MIN_INIT;
        m_max = '0;
        n_cmp += 2;
        if (temp_min !== m_min) begin n_err++; $display("FAIL clr_idle_min: got %h want %h", temp_min, m_min); end
        if (temp_max !== m_max) begin n_err++; $display("FAIL clr_idle_max: got %h want %h", temp_max, m_max); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hi_thresh = 12'h300;
        lo_thresh = 12'h100;
        release_reset();
        for (int i = 0; i < N; i++) run_slot(12'h400, 1'b0);
        for (int i = 0; i < N - 1; i++) run_slot(12'h600, 1'b0);
        lclk_rst = 1'b1;
        tick();
        n_cmp += 6;
        if (avg_temp !== 12'h000)    begin n_err++; $display("FAIL mid_rst_avg: got %h want 000", avg_temp); end
        if (avg_valid !== 1'b0)      begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", avg_valid); end
        if (temp_min !== 12'hFFF)    begin n_err++; $display("FAIL mid_rst_min: got %h want fff", temp_min); end
        if (temp_max !== 12'h000)    begin n_err++; $display("FAIL mid_rst_max: got %h want 000", temp_max); end
        if (over_temp !== 1'b0)      begin n_err++; $display("FAIL mid_rst_ot: got %b want 0", over_temp); end
        if (over_temp_cnt !== 16'h0) begin n_err++; $display("FAIL mid_rst_cnt: got %h want 0000", over_temp_cnt); end
        tick();
        release_reset();
        for (int i = 0; i < N; i++) run_slot(12'h200, 1'b0);
        n_cmp += 2;
        if (over_temp !== m_ot)      begin n_err++; $display("FAIL mid_after_ot: got %b want %b", over_temp, m_ot); end
        if (over_temp_cnt !== m_cnt) begin n_err++; $display("FAIL mid_after_cnt: got %h want %h", over_temp_cnt, m_cnt); end
        hi_thresh = 12'hFFF;
        lo_thresh = 12'h000;
    endtask

    task automatic wait_ot2(input logic want, input string tag);
        int k;
        k = 0;
        while (ot2 !== want && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (ot2 !== want) begin
            n_err++;
            $display("FAIL %s: over_temp=%b after 20 cycles, want %b", tag, ot2, want);
        end
    endtask

    task automatic test_saturation();
        lclk_rst = 1'b1;
        hi2      = 12'h800;
        lo2      = 12'h400;
        temp2    = 12'h900;
        rst2     = 1'b0;
        wait_ot2(1'b1, "sat_first_set");
        n_cmp++;
        if (cnt2 !== 16'h0001) begin n_err++; $display("FAIL sat_first_cnt: got %h want 0001", cnt2); end
        force dut2.over_temp_cnt = 16'hFFFE;
        tick();
        release dut2.over_temp_cnt;
        temp2 = 12'h100;
        wait_ot2(1'b0, "sat_clear1");
        temp2 = 12'h900;
        wait_ot2(1'b1, "sat_set1");
        n_cmp++;
        if (cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h want ffff", cnt2); end
        temp2 = 12'h100;
        wait_ot2(1'b0, "sat_clear2");
        temp2 = 12'h900;
        wait_ot2(1'b1, "sat_set2");
        n_cmp++;
        if (cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", cnt2); end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        lclk_rst    = 1'b1;
        device_temp = '0;
        hi_thresh   = 12'hFFF;
        lo_thresh   = 12'h000;
        minmax_clr  = 1'b0;
        rst2        = 1'b1;
        temp2       = '0;
        hi2         = 12'hFFF;
        lo2         = 12'h000;

        test_reset();
        test_steady();
        test_truncation();
        test_zero_drop();
        test_alarm();
        test_minmax_clr();
        test_reset_mid();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
